dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_responder_if.sv | 24 ++
 rtl/dmem_array.sv | 21 ++
 rtl/dmem_responder.sv | 126 ++++++++++++
 tb/tb_dmem_responder.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// dmem_responder shared types and default sizing.
// Optional misalignment check: define DMEM_ALIGN_CHK_EN.
package dmem_pkg;

  localparam int DEF_LATENCY    = 4;
  localparam int DEF_DEPTH_LOG2 = 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Memory-stage request/response bundle for dmem_responder.
// Master is the memory stage; slave is the responder.
interface dmem_responder_if;

  logic        req_en;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        stall;
  logic        done;
  logic [15:0] rdata;
  logic        err;

  modport master (
    output req_en, req_wr, req_addr, req_wdata,
    input  stall, done, rdata, err
  );

  modport slave (
    input  req_en, req_wr, req_addr, req_wdata,
    output stall, done, rdata, err
  );

endinterface

// File: rtl/dmem_array.sv
// 16-bit word storage: synchronous write, registered read.
// Deliberately unreset so a reset never disturbs contents.
module dmem_array #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [15:0]           wdata,
  output logic [15:0]           q
);

  logic [15:0] mem [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) q <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder with stall/done handshake.
// Define DMEM_ALIGN_CHK_EN to flag and suppress odd-address accesses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int LATENCY    = DEF_LATENCY,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_responder_if.slave  bus
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t      state, state_d;
  logic [3:0]  cnt, cnt_d;
  logic        wr_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        accept;
  logic        fire;
  logic        live;
  logic        acc_wr;
  logic [15:0] acc_addr;
  logic [15:0] acc_wdata;
  logic        mis;
  logic        rd_seen;
  logic [15:0] q;
  logic        unused_bits;

  // LATENCY=1 accesses on the accept edge, so IDLE uses live inputs
  assign live      = (state == IDLE);
  assign acc_wr    = live ? bus.req_wr    : wr_q;
  assign acc_addr  = live ? bus.req_addr  : addr_q;
  assign acc_wdata = live ? bus.req_wdata : wdata_q;

`ifdef DMEM_ALIGN_CHK_EN
  assign mis = acc_addr[0];
`else
  assign mis = 1'b0;
`endif

  assign unused_bits = ^{acc_addr[15:DEPTH_LOG2+1], acc_addr[0]};

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    accept  = 1'b0;
    fire    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req_en && rst_n) begin
          accept = 1'b1;
          cnt_d  = CNT_INIT;
          if (LATENCY > 1) begin
            state_d = BUSY;
          end else begin
            state_d = DONE;
            fire    = 1'b1;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_d = DONE;
          fire    = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      rd_seen <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (accept) begin
        wr_q    <= bus.req_wr;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (fire && !acc_wr && !mis) rd_seen <= 1'b1;
    end
  end

  dmem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .we    (fire & acc_wr & ~mis),
    .re    (fire & ~acc_wr & ~mis),
    .addr  (acc_addr[DEPTH_LOG2:1]),
    .wdata (acc_wdata),
    .q     (q)
  );

`ifdef DMEM_ALIGN_CHK_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= fire & mis;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  // q is unreset, so rdata reads zero until a read has completed
  assign bus.rdata = rd_seen ? q : 16'h0000;
  assign bus.done  = (state == DONE);
  assign bus.stall = rst_n &
                     ((live & bus.req_en) | (state == BUSY));

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (LATENCY=4 and LATENCY=1).
// Honours DMEM_ALIGN_CHK_EN in its expected values.
module tb_dmem_responder;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  int          lat;
  int          sc;
  int          dn;
  int          d1;
  int          d2;
  logic        s5;
  logic        s6;
  logic [15:0] rd;
  logic        er;
  vec_t        v [13];

  always #5 clk = ~clk;

  dmem_responder_if b4 ();
  dmem_responder_if b1 ();

  dmem_responder #(
    .LATENCY    (4),
    .DEPTH_LOG2 (8)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b4.slave)
  );

  dmem_responder #(
    .LATENCY    (1),
    .DEPTH_LOG2 (8)
  ) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1.slave)
  );

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic en,
                       input logic wr, input logic [15:0] a,
                       input logic [15:0] d);
    if (sel) begin
      b1.req_en = en; b1.req_wr = wr;
      b1.req_addr = a; b1.req_wdata = d;
    end else begin
      b4.req_en = en; b4.req_wr = wr;
      b4.req_addr = a; b4.req_wdata = d;
    end
  endtask

  task automatic access(input bit sel, input logic wr,
                        input logic [15:0] a,
                        input logic [15:0] d,
                        input int drop_at,
                        output int done_cyc,
                        output int stall_cnt,
                        output logic [15:0] rdv,
                        output logic erv);
    int cyc;
    bit got;
    @(negedge clk);
    drive(sel, 1'b1, wr, a, d);
    cyc = 0; got = 0; done_cyc = 0;
    stall_cnt = 0; rdv = 16'h0; erv = 1'b0;
    while (!got && cyc < 40) begin
      #1;
      cyc++;
      if (sel ? b1.stall : b4.stall) stall_cnt++;
      if (sel ? b1.done : b4.done) begin
        got = 1; done_cyc = cyc;
        rdv = sel ? b1.rdata : b4.rdata;
        erv = sel ? b1.err : b4.err;
      end
      @(negedge clk);
      if (cyc == drop_at) drive(sel, 1'b0, ~wr, ~a, ~d);
    end
    drive(sel, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    v[0]  = '{1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0};
    v[1]  = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
    v[2]  = '{1'b1, 16'h0002, 16'h1234, 16'hBEEF, 1'b0};
    v[3]  = '{1'b0, 16'h0202, 16'h0000, 16'h1234, 1'b0};
    v[4]  = '{1'b1, 16'h0004, 16'h0F0F, 16'h1234, 1'b0};
    v[5]  = '{1'b1, 16'hFF20, 16'h5A5A, 16'h1234, 1'b0};
    v[6]  = '{1'b0, 16'h0120, 16'h0000, 16'h5A5A, 1'b0};
    v[7]  = '{1'b1, 16'h0020, 16'h1111, 16'h5A5A, 1'b0};
    v[8]  = '{1'b0, 16'h0020, 16'h0000, 16'h1111, 1'b0};
    v[9]  = '{1'b1, 16'h0010, 16'hFFFF, 16'h1111, 1'b0};
    v[10] = '{1'b0, 16'h0010, 16'h0000, 16'hFFFF, 1'b0};
`ifdef DMEM_ALIGN_CHK_EN
    v[11] = '{1'b1, 16'h0005, 16'hAAAA, 16'hFFFF, 1'b1};
    v[12] = '{1'b0, 16'h0004, 16'h0000, 16'h0F0F, 1'b0};
`else
    v[11] = '{1'b1, 16'h0005, 16'hAAAA, 16'hFFFF, 1'b0};
    v[12] = '{1'b0, 16'h0004, 16'h0000, 16'hAAAA, 1'b0};
`endif

    // request held high during reset must not stall
    drive(0, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
    drive(1, 1'b1, 1'b1, 16'h0000, 16'h4321);
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", 32'(b4.stall), 32'd0);
    check("rst_stall1", 32'(b1.stall), 32'd0);
    check("rst_done", 32'(b4.done), 32'd0);
    check("rst_err", 32'(b4.err), 32'd0);
    check("rst_rdata", 32'(b4.rdata), 32'h0);
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      access(0, v[i].wr, v[i].addr, v[i].wdata, 0,
             lat, sc, rd, er);
      check($sformatf("v%0d_lat", i), 32'(lat), 32'd5);
      check($sformatf("v%0d_stall", i), 32'(sc), 32'd4);
      check($sformatf("v%0d_rdata", i), 32'(rd),
            32'(v[i].exp_rdata));
      check($sformatf("v%0d_err", i), 32'(er),
            32'(v[i].exp_err));
    end

    // reset on cycle 2 of a write discards it
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 16'h0020, 16'h5555);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mr_stall", 32'(b4.stall), 32'd0);
    check("mr_rdata", 32'(b4.rdata), 32'h0);
    dn = 0; sc = 0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (b4.done) dn++;
      if (b4.stall) sc++;
    end
    check("mr_done", 32'(dn), 32'd0);
    check("mr_stall_hold", 32'(sc), 32'd0);
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    access(0, 1'b0, 16'h0020, 16'h0, 0, lat, sc, rd, er);
    check("mr_lat", 32'(lat), 32'd5);
    check("mr_old", 32'(rd), 32'h1111);

    // req_en dropped while busy: access completes on latched values
    access(0, 1'b1, 16'h0030, 16'h7777, 1, lat, sc, rd, er);
    check("drop_lat", 32'(lat), 32'd5);
    access(0, 1'b0, 16'h0030, 16'h0, 0, lat, sc, rd, er);
    check("drop_rdata", 32'(rd), 32'h7777);

    // held request: one done per acceptance, one IDLE gap
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 16'h0010, 16'h0);
    dn = 0; d1 = 0; d2 = 0; s5 = 1'bx; s6 = 1'bx;
    for (int c = 1; c <= 14; c++) begin
      #1;
      if (b4.done) begin
        dn++;
        if (dn == 1) d1 = c;
        if (dn == 2) d2 = c;
      end
      if (c == 5) s5 = b4.stall;
      if (c == 6) s6 = b4.stall;
      @(negedge clk);
    end
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    check("hold_cnt", 32'(dn), 32'd2);
    check("hold_d1", 32'(d1), 32'd5);
    check("hold_d2", 32'(d2), 32'd10);
    check("hold_s5", 32'(s5), 32'd0);
    check("hold_s6", 32'(s6), 32'd1);
    repeat (6) @(negedge clk);

    // minimum latency instance
    access(1, 1'b1, 16'h0000, 16'h4321, 0, lat, sc, rd, er);
    check("l1_wlat", 32'(lat), 32'd2);
    check("l1_wstall", 32'(sc), 32'd1);
    access(1, 1'b0, 16'h0000, 16'h0, 0, lat, sc, rd, er);
    check("l1_rlat", 32'(lat), 32'd2);
    check("l1_rstall", 32'(sc), 32'd1);
    check("l1_rdata", 32'(rd), 32'h4321);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
